// File: rtl/mem_pipe_param_if.sv
// Request/response bundle between the cache refill/writeback logic (master) and the backing memory (slave).
// A request transfers on a rising edge where req_valid_i && req_ready_o. req_ready_o never depends on req_valid_i,
// and responses carry no backpressure.
interface mem_pipe_param_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 128,
    parameter int ID_WIDTH   = 4
);
    logic                    req_valid_i;
    logic                    req_ready_o;
    logic                    req_wr_i;
    logic                    req_is_instr_i;
    logic [ID_WIDTH-1:0]     req_id_i;
    logic [ADDR_WIDTH-1:0]   address_i;
    logic [DATA_WIDTH-1:0]   wr_data_i;
    logic [DATA_WIDTH/8-1:0] wr_be_i;

    logic                    rsp_valid_o;
    logic                    rsp_is_wr_o;
    logic                    rsp_is_instr_o;
    logic [ID_WIDTH-1:0]     rsp_id_o;
    logic [DATA_WIDTH-1:0]   rsp_data_o;

    modport slave (
        input  req_valid_i, req_wr_i, req_is_instr_i, req_id_i, address_i, wr_data_i, wr_be_i,
        output req_ready_o, rsp_valid_o, rsp_is_wr_o, rsp_is_instr_o, rsp_id_o, rsp_data_o
    );

    modport master (
        output req_valid_i, req_wr_i, req_is_instr_i, req_id_i, address_i, wr_data_i, wr_be_i,
        input  req_ready_o, rsp_valid_o, rsp_is_wr_o, rsp_is_instr_o, rsp_id_o, rsp_data_o
    );
endinterface

// File: rtl/mem_pipe_param.sv
// Fixed-latency, byte-addressed backing memory: LATENCY-stage request pipeline with the array access at
// ACCESS_STAGE, byte-enable writes, in-order responses and a cap on requests in flight.
module mem_pipe_param #(
    parameter int    MEM_SIZE        = 65536,
    parameter int    ADDR_WIDTH      = 16,
    parameter int    DATA_WIDTH      = 128,
    parameter int    LATENCY         = 10,
    parameter int    ACCESS_STAGE    = 5,
    parameter int    MAX_OUTSTANDING = 4,
    parameter int    ID_WIDTH        = 4,
    parameter string INIT_FILE       = ""
) (
    input  logic clk_i,
    input  logic rst_i,
    mem_pipe_param_if.slave bus,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
`ifndef SYNTHESIS
    ,
    output logic [8*MEM_SIZE-1:0] debug_mem_o
`endif
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = $clog2(MEM_SIZE);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [7:0] mem_q [MEM_SIZE];

    logic                  st_valid_q [1:LATENCY];
    logic                  st_wr_q    [1:LATENCY];
    logic                  st_instr_q [1:LATENCY];
    logic [ID_WIDTH-1:0]   st_id_q    [1:LATENCY];
    logic [ADDR_WIDTH-1:0] st_addr_q  [1:LATENCY];
    logic [DATA_WIDTH-1:0] st_wdata_q [1:LATENCY];
    logic [NB-1:0]         st_be_q    [1:LATENCY];
    logic [DATA_WIDTH-1:0] st_data_q  [1:LATENCY];

    logic [CNT_W-1:0]      outstanding_q, outstanding_d;
    logic [DATA_WIDTH-1:0] rd_line;
    logic                  accept, retire;

    // Lanes past the top of the array wrap back to byte 0.
    function automatic logic [IDX_W-1:0] lane_idx(input logic [ADDR_WIDTH-1:0] base, input int lane);
        logic [ADDR_WIDTH:0] sum;
        sum = {1'b0, base} + (ADDR_WIDTH+1)'(lane);
        return IDX_W'(sum % (ADDR_WIDTH+1)'(MEM_SIZE));
    endfunction

    assign bus.req_ready_o = (outstanding_q < CNT_W'(MAX_OUTSTANDING));
    assign accept          = bus.req_valid_i && bus.req_ready_o;
    assign retire          = st_valid_q[LATENCY];

    always_comb begin
        rd_line = '0;
        for (int i = 0; i < NB; i++) begin
            rd_line[8*i +: 8] = mem_q[lane_idx(st_addr_q[ACCESS_STAGE], i)];
        end
    end

    always_comb begin
        outstanding_d = outstanding_q;
        if (accept && !retire) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (!accept && retire) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end
    end

    // The array has no reset so its contents survive a mid-operation reset.
    always_ff @(posedge clk_i) begin
        if (st_valid_q[ACCESS_STAGE] && st_wr_q[ACCESS_STAGE]) begin
            for (int i = 0; i < NB; i++) begin
                if (st_be_q[ACCESS_STAGE][i]) begin
                    mem_q[lane_idx(st_addr_q[ACCESS_STAGE], i)] <= st_wdata_q[ACCESS_STAGE][8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 1; k <= LATENCY; k++) begin
                st_valid_q[k] <= 1'b0;
                st_wr_q[k]    <= 1'b0;
                st_instr_q[k] <= 1'b0;
                st_id_q[k]    <= '0;
                st_addr_q[k]  <= '0;
                st_wdata_q[k] <= '0;
                st_be_q[k]    <= '0;
                st_data_q[k]  <= '0;
            end
            outstanding_q <= '0;
        end else begin
            st_valid_q[1] <= accept;
            st_wr_q[1]    <= bus.req_wr_i;
            st_instr_q[1] <= bus.req_is_instr_i;
            st_id_q[1]    <= bus.req_id_i;
            st_addr_q[1]  <= bus.address_i;
            st_wdata_q[1] <= bus.wr_data_i;
            st_be_q[1]    <= bus.wr_be_i;
            st_data_q[1]  <= '0;
            for (int k = 2; k <= LATENCY; k++) begin
                st_valid_q[k] <= st_valid_q[k-1];
                st_wr_q[k]    <= st_wr_q[k-1];
                st_instr_q[k] <= st_instr_q[k-1];
                st_id_q[k]    <= st_id_q[k-1];
                st_addr_q[k]  <= st_addr_q[k-1];
                st_wdata_q[k] <= st_wdata_q[k-1];
                st_be_q[k]    <= st_be_q[k-1];
                // Read data enters right after the access stage; write acks carry zero.
                if (k == ACCESS_STAGE + 1) begin
                    st_data_q[k] <= st_wr_q[k-1] ? '0 : rd_line;
                end else begin
                    st_data_q[k] <= st_data_q[k-1];
                end
            end
            outstanding_q <= outstanding_d;
        end
    end

    assign bus.rsp_valid_o    = st_valid_q[LATENCY];
    assign bus.rsp_is_wr_o    = st_wr_q[LATENCY];
    assign bus.rsp_is_instr_o = st_instr_q[LATENCY];
    assign bus.rsp_id_o       = st_id_q[LATENCY];
    assign bus.rsp_data_o     = st_data_q[LATENCY];
    assign outstanding_o      = outstanding_q;

`ifndef SYNTHESIS
    always_comb begin
        debug_mem_o = '0;
        for (int b = 0; b < MEM_SIZE; b++) begin
            debug_mem_o[8*b +: 8] = mem_q[b];
        end
    end
`endif
endmodule

// File: tb/tb_mem_pipe_param.sv
// Directed bench for mem_pipe_param: a default instance driven from a vector table plus multi-cycle
// sequences (backpressure, reset mid-flight), and a short-latency instance for the reparametrised case.
module tb_mem_pipe_param;
    localparam int LAT  = 10;
    localparam int MAXO = 4;
    localparam int LAT6 = 3;
    localparam int EXP_W = 32 + 1 + 1 + 4 + 128;

    logic clk_i;
    logic rst_i;
    logic [2:0] outstanding;
    logic [0:0] outstanding6;
    logic [8*65536-1:0] dbg_mem;
    logic [8*256-1:0]   dbg_mem6;

    mem_pipe_param_if #(.ADDR_WIDTH(16), .DATA_WIDTH(128), .ID_WIDTH(4)) bus ();
    mem_pipe_param_if #(.ADDR_WIDTH(8),  .DATA_WIDTH(128), .ID_WIDTH(4)) bus6 ();

    mem_pipe_param #(
        .MEM_SIZE(65536), .ADDR_WIDTH(16), .DATA_WIDTH(128), .LATENCY(LAT),
        .ACCESS_STAGE(5), .MAX_OUTSTANDING(MAXO), .ID_WIDTH(4), .INIT_FILE("")
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .bus(bus.slave),
        .outstanding_o(outstanding), .debug_mem_o(dbg_mem)
    );

    mem_pipe_param #(
        .MEM_SIZE(256), .ADDR_WIDTH(8), .DATA_WIDTH(128), .LATENCY(LAT6),
        .ACCESS_STAGE(1), .MAX_OUTSTANDING(1), .ID_WIDTH(4), .INIT_FILE("")
    ) dut6 (
        .clk_i(clk_i), .rst_i(rst_i), .bus(bus6.slave),
        .outstanding_o(outstanding6), .debug_mem_o(dbg_mem6)
    );

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [EXP_W-1:0] exp_q [$];

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (!rst_i && bus.rsp_valid_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 192'(bus.rsp_valid_o), 192'(0));
            end else begin
                check("rsp", 192'({32'(cyc), bus.rsp_is_wr_o, bus.rsp_is_instr_o, bus.rsp_id_o, bus.rsp_data_o}),
                      192'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    typedef struct {
        logic         wr;
        logic         instr;
        logic [3:0]   id;
        logic [15:0]  addr;
        logic [127:0] wdata;
        logic [15:0]  be;
        logic [127:0] exp_data;
    } vec_t;

    task automatic send(input vec_t v);
        int w;
        bus.req_wr_i       = v.wr;
        bus.req_is_instr_i = v.instr;
        bus.req_id_i       = v.id;
        bus.address_i      = v.addr;
        bus.wr_data_i      = v.wdata;
        bus.wr_be_i        = v.be;
        bus.req_valid_i    = 1'b1;
        w = 0;
        while (!bus.req_ready_o && w < 100) begin
            step();
            w++;
        end
        if (!bus.req_ready_o) begin
            check("send_timeout", 192'(bus.req_ready_o), 192'(1));
        end else begin
            exp_q.push_back({32'(cyc + LAT), v.wr, v.instr, v.id, v.exp_data});
            step();
        end
        bus.req_valid_i = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            step();
            w++;
        end
        check("drain_pending", 192'(exp_q.size()), 192'(0));
        step();
        check("drain_outstanding", 192'(outstanding), 192'(0));
        check("drain_ready", 192'(bus.req_ready_o), 192'(1));
    endtask

    localparam logic [127:0] PAT  = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] PAT3 = 128'h3F3E3D3C3B3A39383736353433323130;

    vec_t vecs [15];
    vec_t t6 [3];

    initial begin
        int acc8, accepted, bad_ready, post, rsp_cnt, n, r;
        bit seen_rsp, just_acc;
        int acc6 [3];
        logic [15:0] a;

        vecs[0]  = '{1'b1, 1'b0, 4'd1,  16'h0040, {16{8'hA5}}, 16'hFFFF, 128'h0};
        vecs[1]  = '{1'b0, 1'b0, 4'd2,  16'h0040, 128'h0,      16'h0000, {16{8'hA5}}};
        vecs[2]  = '{1'b1, 1'b0, 4'd3,  16'h0080, {16{8'h11}}, 16'hFFFF, 128'h0};
        vecs[3]  = '{1'b1, 1'b0, 4'd4,  16'h0080, {16{8'hFF}}, 16'h0003, 128'h0};
        vecs[4]  = '{1'b0, 1'b1, 4'd5,  16'h0080, 128'h0,      16'h0000, {{14{8'h11}}, 16'hFFFF}};
        vecs[5]  = '{1'b1, 1'b0, 4'd6,  16'hFFF8, PAT,         16'hFFFF, 128'h0};
        vecs[6]  = '{1'b0, 1'b1, 4'd7,  16'hFFF8, 128'h0,      16'h0000, PAT};
        vecs[7]  = '{1'b1, 1'b0, 4'd8,  16'h0048, PAT3,        16'hFFFF, 128'h0};
        vecs[8]  = '{1'b0, 1'b0, 4'd9,  16'h0040, 128'h0,      16'h0000, {64'h3736353433323130, {8{8'hA5}}}};
        vecs[9]  = '{1'b0, 1'b0, 4'd10, 16'h0080, 128'h0,      16'h0000, {{14{8'h11}}, 16'hFFFF}};
        vecs[10] = '{1'b1, 1'b0, 4'd11, 16'h0080, {16{8'h22}}, 16'hFFFF, 128'h0};
        vecs[11] = '{1'b0, 1'b0, 4'd12, 16'h0080, 128'h0,      16'h0000, {16{8'h22}}};
        vecs[12] = '{1'b1, 1'b0, 4'd13, 16'hFFF8, {16{8'hFF}}, 16'h0000, 128'h0};
        vecs[13] = '{1'b0, 1'b0, 4'd14, 16'hFFF8, 128'h0,      16'h0000, PAT};
        vecs[14] = '{1'b0, 1'b0, 4'd15, 16'h0041, 128'h0,      16'h0000, {72'h383736353433323130, {7{8'hA5}}}};

        t6[0] = '{1'b1, 1'b0, 4'd3,  16'h00FE, PAT,    16'hFFFF, 128'h0};
        t6[1] = '{1'b0, 1'b0, 4'd9,  16'h00FE, 128'h0, 16'h0000, PAT};
        t6[2] = '{1'b0, 1'b1, 4'd12, 16'h00FE, 128'h0, 16'h0000, PAT};

        rst_i = 1'b1;
        bus.req_valid_i = 1'b0; bus.req_wr_i = 1'b0; bus.req_is_instr_i = 1'b0; bus.req_id_i = '0;
        bus.address_i = '0; bus.wr_data_i = '0; bus.wr_be_i = '0;
        bus6.req_valid_i = 1'b0; bus6.req_wr_i = 1'b0; bus6.req_is_instr_i = 1'b0; bus6.req_id_i = '0;
        bus6.address_i = '0; bus6.wr_data_i = '0; bus6.wr_be_i = '0;
        repeat (3) step();
        rst_i = 1'b0;

        // reset state
        check("rst_rsp_valid", 192'(bus.rsp_valid_o), 192'(0));
        check("rst_rsp_is_wr", 192'(bus.rsp_is_wr_o), 192'(0));
        check("rst_rsp_is_instr", 192'(bus.rsp_is_instr_o), 192'(0));
        check("rst_rsp_id", 192'(bus.rsp_id_o), 192'(0));
        check("rst_rsp_data", 192'(bus.rsp_data_o), 192'(0));
        check("rst_outstanding", 192'(outstanding), 192'(0));
        check("rst_ready", 192'(bus.req_ready_o), 192'(1));
        check("rst6_ready", 192'(bus6.req_ready_o), 192'(1));
        step();

        // table-driven traffic, issued back to back
        for (int i = 0; i < 15; i++) send(vecs[i]);
        drain();

        // wrapped write landed in the top and bottom of the array
        for (int i = 0; i < 16; i++) begin
            a = 16'hFFF8 + 16'(i);
            check("wrap_byte", 192'(dbg_mem[8*int'(a) +: 8]), 192'(i));
        end

        // backpressure: valid held high, ids 0..7
        bus.req_wr_i = 1'b0; bus.req_is_instr_i = 1'b0; bus.address_i = 16'h0080;
        bus.wr_be_i = '0; bus.wr_data_i = '0; bus.req_valid_i = 1'b1;
        acc8 = 0; accepted = 0; bad_ready = 0; post = -1; seen_rsp = 1'b0;
        for (int c = 0; c < 200 && accepted < 8; c++) begin
            bus.req_id_i = 4'(accepted);
            if (!seen_rsp && bus.rsp_valid_o) begin
                seen_rsp = 1'b1;
                post = c + 1;
                check("t3_first_rsp_outstanding", 192'(outstanding), 192'(4));
                check("t3_first_rsp_ready", 192'(bus.req_ready_o), 192'(0));
            end
            if (c == post) begin
                check("t3_after_rsp_outstanding", 192'(outstanding), 192'(3));
                check("t3_after_rsp_ready", 192'(bus.req_ready_o), 192'(1));
            end
            if (!seen_rsp && c >= MAXO && bus.req_ready_o) bad_ready++;
            if (bus.req_ready_o) begin
                exp_q.push_back({32'(cyc + LAT), 1'b0, 1'b0, 4'(accepted), {16{8'h22}}});
                if (c < 8) acc8++;
                accepted++;
            end
            step();
        end
        bus.req_valid_i = 1'b0;
        check("t3_accepts_in_8", 192'(acc8), 192'(MAXO));
        check("t3_ready_low_until_rsp", 192'(bad_ready), 192'(0));
        check("t3_all_accepted", 192'(accepted), 192'(8));
        drain();

        // reset mid-flight drops in-flight reads, keeps the array
        send('{1'b0, 1'b0, 4'd1, 16'h0080, 128'h0, 16'h0000, {16{8'h22}}});
        send('{1'b0, 1'b0, 4'd2, 16'hFFF8, 128'h0, 16'h0000, PAT});
        step();
        step();
        rst_i = 1'b1;
        exp_q.delete();
        step();
        rst_i = 1'b0;
        check("t5_outstanding", 192'(outstanding), 192'(0));
        check("t5_ready", 192'(bus.req_ready_o), 192'(1));
        check("t5_rsp_valid", 192'(bus.rsp_valid_o), 192'(0));
        check("t5_rsp_id", 192'(bus.rsp_id_o), 192'(0));
        rsp_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (bus.rsp_valid_o) rsp_cnt++;
        end
        check("t5_no_rsp", 192'(rsp_cnt), 192'(0));
        send('{1'b0, 1'b0, 4'd3, 16'h0080, 128'h0, 16'h0000, {16{8'h22}}});
        send('{1'b0, 1'b1, 4'd4, 16'hFFF8, 128'h0, 16'h0000, PAT});
        drain();

        // short-latency instance, valid held high for three requests
        n = 0; r = 0;
        bus6.req_wr_i = t6[0].wr; bus6.req_is_instr_i = t6[0].instr; bus6.req_id_i = t6[0].id;
        bus6.address_i = t6[0].addr[7:0]; bus6.wr_data_i = t6[0].wdata; bus6.wr_be_i = t6[0].be;
        bus6.req_valid_i = 1'b1;
        for (int c = 0; c < 60 && r < 3; c++) begin
            if (bus6.rsp_valid_o) begin
                if (r < n) begin
                    check("t6_rsp",
                          192'({32'(cyc), bus6.rsp_is_wr_o, bus6.rsp_is_instr_o, bus6.rsp_id_o, bus6.rsp_data_o}),
                          192'({32'(acc6[r] + LAT6 - 1), t6[r].wr, t6[r].instr, t6[r].id, t6[r].exp_data}));
                end else begin
                    check("t6_unexpected_rsp", 192'(bus6.rsp_valid_o), 192'(0));
                end
                r++;
            end
            just_acc = 1'b0;
            if (n < 3 && bus6.req_valid_i && bus6.req_ready_o) begin
                acc6[n] = cyc + 1;
                n++;
                just_acc = 1'b1;
            end
            step();
            if (just_acc) begin
                if (n < 3) begin
                    bus6.req_wr_i = t6[n].wr; bus6.req_is_instr_i = t6[n].instr; bus6.req_id_i = t6[n].id;
                    bus6.address_i = t6[n].addr[7:0]; bus6.wr_data_i = t6[n].wdata; bus6.wr_be_i = t6[n].be;
                end else begin
                    bus6.req_valid_i = 1'b0;
                end
            end
        end
        bus6.req_valid_i = 1'b0;
        check("t6_rsp_count", 192'(r), 192'(3));
        if (n == 3) begin
            check("t6_spacing_01", 192'(acc6[1] - acc6[0]), 192'(LAT6 + 1));
            check("t6_spacing_12", 192'(acc6[2] - acc6[1]), 192'(LAT6 + 1));
        end else begin
            check("t6_accept_count", 192'(n), 192'(3));
        end
        check("t6_wrap_byte_ff", 192'(dbg_mem6[8*255 +: 8]), 192'(8'h01));
        check("t6_wrap_byte_00", 192'(dbg_mem6[0 +: 8]), 192'(8'h02));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
